// File: rtl/vc_output_channel.sv
// vc_output_channel: round-robin front end feeding two phase-alternating VC
// buffers (even/odd) that share one registered send/ready outbound link.
module vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_d,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  occ
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_d;

  assign head = mem[rd_ptr];
endmodule

module vc_output_channel #(
  parameter int DATA_W = 64,
  parameter int N_IN   = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   polarity_out,
  input  logic [N_IN-1:0]        req_v,
  input  logic [N_IN*DATA_W-1:0] req_d,
  output logic [N_IN-1:0]        gnt,
  input  logic                   ro,
  output logic                   so,
  output logic [DATA_W-1:0]      dout,
  output logic [CNT_W-1:0]       occ0,
  output logic [CNT_W-1:0]       occ1
);
  localparam int RR_W = $clog2(N_IN);

  logic [N_IN-1:0][DATA_W-1:0] req_arr;
  logic [1:0][DATA_W-1:0]      head;
  logic [1:0][CNT_W-1:0]       occ;
  logic [N_IN-1:0]             elig, gnt_c;
  logic [RR_W-1:0]             rr, gidx;
  logic                        acc_vc, push, pop;

  assign req_arr = req_d;
  assign acc_vc  = ~polarity_out;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_IN; i++)
      elig[i] = req_v[i] && (req_arr[i][DATA_W-1] == acc_vc) &&
                (occ[acc_vc] < CNT_W'(DEPTH));
  end

  // Round-robin search starting at rr, wrapping modulo N_IN.
  always_comb begin
    int  idx;
    logic found;
    gnt_c = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        gidx       = RR_W'(idx);
      end
    end
  end

  // Grant is suppressed while reset is held so nothing leaks out combinationally.
  assign gnt  = reset ? gnt_c : '0;
  assign push = |gnt;
  assign pop  = ro && (occ[polarity_out] != '0);

  for (genvar v = 0; v < 2; v++) begin : g_vc
    vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push && (acc_vc == 1'(v))),
      .push_d (req_arr[gidx]),
      .pop    (pop && (polarity_out == 1'(v))),
      .head   (head[v]),
      .occ    (occ[v])
    );
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      polarity_out <= 1'b0;
      rr           <= '0;
      so           <= 1'b0;
      dout         <= '0;
    end else begin
      polarity_out <= ~polarity_out;
      if (push) rr <= (gidx == RR_W'(N_IN-1)) ? '0 : gidx + 1'b1;
      so   <= pop;
      dout <= pop ? head[polarity_out] : '0;
    end

  assign occ0 = occ[0];
  assign occ1 = occ[1];
endmodule

// File: tb/tb_vc_output_channel.sv
// Directed bench for vc_output_channel: reset, latency, round-robin,
// backpressure, VC independence and mid-operation reset.
module tb_vc_output_channel;
  logic         clk, reset, ro, so, polarity_out;
  logic [3:0]   req_v, gnt;
  logic [255:0] req_d;
  logic [63:0]  dout;
  logic [1:0]   occ0, occ1;
  int checks = 0, failures = 0;

  vc_output_channel #(.DATA_W(64), .N_IN(4), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .polarity_out(polarity_out), .req_v(req_v),
    .req_d(req_d), .gnt(gnt), .ro(ro), .so(so), .dout(dout),
    .occ0(occ0), .occ1(occ1));

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [63:0] d);
    req_d[i*64 +: 64] = d;
  endtask

  // Leaves the bench at a negedge with reset released and polarity_out=0.
  task automatic do_reset();
    @(negedge clk);
    reset = 0; req_v = '0; ro = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    logic exp_p;
    reset = 0; ro = 1;
    for (int i = 0; i < 4; i++) set_req(i, 64'hA002000000000010 + i);
    req_v = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({polarity_out, so, dout, gnt, occ0, occ1} !== '0) begin
        failures++;
        $display("FAIL reset_outputs p=%0b so=%0b do=%0h gnt=%0h occ0=%0d occ1=%0d want all 0",
                 polarity_out, so, dout, gnt, occ0, occ1);
      end
    end
    req_v = '0; ro = 0;
    @(negedge clk); reset = 1;
    exp_p = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (polarity_out !== exp_p) begin
        failures++;
        $display("FAIL reset_polarity cyc=%0d got=%0b want=%0b", c, polarity_out, exp_p);
      end
      exp_p = ~exp_p;
    end
  endtask

  task automatic test_single();
    logic [63:0] pkt = 64'h200200000000FA50;
    do_reset(); ro = 1;
    set_req(0, pkt); req_v = 4'b0001;
    #1; checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL single_nogrant_p0 got=%0h want=0", gnt); end
    @(negedge clk); #1; checks++;
    if (gnt !== 4'b0001 || polarity_out !== 1) begin
      failures++; $display("FAIL single_grant got=%0h p=%0b want=1 p=1", gnt, polarity_out);
    end
    @(posedge clk); #1; req_v = '0;
    @(negedge clk); checks++;
    if (occ0 !== 2'd1 || so !== 0) begin
      failures++; $display("FAIL single_occ_after_push occ0=%0d so=%0b want occ0=1 so=0", occ0, so);
    end
    @(negedge clk); checks++;
    if (so !== 1 || dout !== pkt || polarity_out !== 1 || occ0 !== 2'd0) begin
      failures++; $display("FAIL single_send so=%0b do=%0h p=%0b occ0=%0d want 1 %0h 1 0",
                           so, dout, polarity_out, occ0, pkt);
    end
    @(negedge clk); checks++;
    if (so !== 0 || dout !== '0) begin
      failures++; $display("FAIL single_idle so=%0b do=%0h want 0 0", so, dout);
    end
  endtask

  task automatic test_rr();
    int g[$]; int tout[$]; logic [63:0] outs[$]; logic [3:0] gs;
    do_reset(); ro = 1;
    for (int i = 0; i < 4; i++) set_req(i, 64'h2002000000006840 + i);
    req_v = 4'hF;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (so) begin outs.push_back(dout); tout.push_back(c); end
      gs = gnt;
      for (int i = 0; i < 4; i++) if (gs[i]) g.push_back(i);
      if (gs != 0) begin
        checks++;
        if (polarity_out !== 1) begin failures++; $display("FAIL rr_grant_phase got p=%0b want 1", polarity_out); end
      end
      @(posedge clk); #1; req_v = req_v & ~gs;
      @(negedge clk);
    end
    checks++;
    if (g.size() != 4 || outs.size() != 4) begin
      failures++; $display("FAIL rr_counts grants=%0d outs=%0d want 4 4", g.size(), outs.size());
    end
    for (int k = 0; k < g.size() && k < 4; k++) begin
      checks++;
      if (g[k] != k) begin failures++; $display("FAIL rr_grant_order idx=%0d got=%0d want=%0d", k, g[k], k); end
    end
    for (int k = 0; k < outs.size() && k < 4; k++) begin
      checks++;
      if (outs[k] !== 64'h2002000000006840 + k) begin
        failures++; $display("FAIL rr_data idx=%0d got=%0h want=%0h", k, outs[k], 64'h2002000000006840 + k);
      end
      if (k > 0) begin
        checks++;
        if (tout[k] - tout[k-1] != 2) begin
          failures++; $display("FAIL rr_spacing idx=%0d got=%0d want=2", k, tout[k] - tout[k-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int g[$]; logic [63:0] outs[$]; logic [3:0] gs; int early_so = 0;
    do_reset(); ro = 0;
    for (int i = 0; i < 4; i++) set_req(i, 64'hA002000000000001 + i);
    req_v = 4'hF;
    for (int c = 0; c < 28; c++) begin
      if (c == 8) begin
        #1; checks++;
        if (occ1 !== 2'd2 || gnt !== 4'b0 || g.size() != 2 || early_so != 0) begin
          failures++; $display("FAIL bp_full occ1=%0d gnt=%0h grants=%0d so_seen=%0d want 2 0 2 0",
                               occ1, gnt, g.size(), early_so);
        end
        ro = 1;
      end
      #1;
      if (so) begin
        outs.push_back(dout);
        if (ro == 0) early_so++;
        checks++;
        if (polarity_out !== ~dout[63]) begin
          failures++; $display("FAIL bp_phase p=%0b vc=%0b want p=~vc", polarity_out, dout[63]);
        end
      end
      gs = gnt;
      for (int i = 0; i < 4; i++) if (gs[i]) g.push_back(i);
      @(posedge clk); #1; req_v = req_v & ~gs;
      @(negedge clk);
    end
    checks++;
    if (g.size() != 4 || outs.size() != 4) begin
      failures++; $display("FAIL bp_counts grants=%0d outs=%0d want 4 4", g.size(), outs.size());
    end
    for (int k = 0; k < g.size() && k < 4; k++) begin
      checks++;
      if (g[k] != k) begin failures++; $display("FAIL bp_grant_order idx=%0d got=%0d want=%0d", k, g[k], k); end
    end
    for (int k = 0; k < outs.size() && k < 4; k++) begin
      checks++;
      if (outs[k] !== 64'hA002000000000001 + k) begin
        failures++; $display("FAIL bp_data idx=%0d got=%0h want=%0h", k, outs[k], 64'hA002000000000001 + k);
      end
    end
  endtask

  task automatic test_vc_indep();
    logic [3:0] gs; int vc0_out = 0, other_out = 0, bad_occ = 0, req2_g = 0, req3_g = 0;
    do_reset(); ro = 0;
    set_req(0, 64'hA002000000000001); set_req(1, 64'hA002000000000002);
    set_req(2, 64'hA002000000000003); set_req(3, 64'h400200000000C7D4);
    req_v = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      #1; gs = gnt;
      @(posedge clk); #1; req_v = req_v & ~gs;
      @(negedge clk);
    end
    checks++;
    if (occ1 !== 2'd2) begin failures++; $display("FAIL indep_fill occ1=%0d want=2", occ1); end
    req_v = req_v | 4'b1000;
    for (int c = 0; c < 10; c++) begin
      ro = ~polarity_out;
      #1;
      if (so) begin
        if (dout === 64'h400200000000C7D4) vc0_out++; else other_out++;
      end
      if (occ1 !== 2'd2) bad_occ++;
      gs = gnt;
      for (int i = 0; i < 4; i++)
        if (gs[i]) begin
          checks++;
          if (req_d[i*64+63] !== ~polarity_out) begin
            failures++; $display("FAIL indep_wrong_phase req=%0d vc=%0b p=%0b", i, req_d[i*64+63], polarity_out);
          end
        end
      if (gs[2]) req2_g++;
      if (gs[3]) req3_g++;
      @(posedge clk); #1; req_v = req_v & ~gs;
      @(negedge clk);
    end
    checks++;
    if (req3_g != 1 || vc0_out != 1 || other_out != 0) begin
      failures++; $display("FAIL indep_vc0 grants=%0d sent=%0d other=%0d want 1 1 0", req3_g, vc0_out, other_out);
    end
    checks++;
    if (req2_g != 0 || bad_occ != 0) begin
      failures++; $display("FAIL indep_vc1_blocked req2_grants=%0d occ1_bad=%0d want 0 0", req2_g, bad_occ);
    end
    ro = 0; req_v = '0;
  endtask

  task automatic test_mid_reset();
    logic [3:0] gs; int stale = 0; logic reached = 0;
    do_reset(); ro = 0;
    set_req(0, 64'hA002000000000011); set_req(1, 64'hA002000000000012);
    set_req(2, 64'h400200000000C7D4);
    req_v = 4'b0111;
    for (int c = 0; c < 12 && !reached; c++) begin
      #1; gs = gnt;
      @(posedge clk); #1; req_v = req_v & ~gs;
      @(negedge clk);
      if (occ0 === 2'd1 && occ1 === 2'd2) reached = 1;
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL mid_fill occ0=%0d occ1=%0d want 1 2", occ0, occ1); end
    req_v = '0;
    reset = 0; #1;
    checks++;
    if (occ0 !== 0 || occ1 !== 0 || so !== 0 || dout !== '0 || polarity_out !== 0) begin
      failures++; $display("FAIL mid_reset_clear occ0=%0d occ1=%0d so=%0b do=%0h p=%0b want all 0",
                           occ0, occ1, so, dout, polarity_out);
    end
    @(negedge clk); reset = 1; ro = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (so !== 0) stale++;
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL mid_stale got=%0d sends want=0", stale); end
  endtask

  initial begin
    clk = 0; reset = 0; ro = 0; req_v = '0; req_d = '0;
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_vc_indep();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vc_output_channel.md
# vc_output_channel

Parametrised output-port stage for the next-generation ring/mesh router. Collects packets from N_IN internal requesters into two virtual-channel buffers (even/odd) selected by the packet VC bit, and drives one outbound link with the send/ready handshake the router links use. The even/odd phase follows `polarity_out`: one VC accepts internally while the other drains to the link. It adds round-robin arbitration, configurable depth and configurable width.

## Interface

- DATA_W, 64, packet width; VC bit is DATA_W-1
- N_IN, 4, number of internal requesters (>=2)
- DEPTH, 2, entries per VC buffer (>=1, any integer)
- CNT_W, $clog2(DEPTH+1), occupancy counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- polarity_out  out  1  phase bit, toggles every cycle
- req_v  in  N_IN  requester i has a packet
- req_d  in  N_IN*DATA_W  packet of requester i in slice [i*DATA_W +: DATA_W]
- gnt  out  N_IN  one-hot grant, combinational; packet written at that edge
- ro  in  1  downstream ready
- so  out  1  send valid, registered
- do  out  DATA_W  send data, registered; 0 when so=0
- occ0  out  CNT_W  VC0 buffer occupancy
- occ1  out  CNT_W  VC1 buffer occupancy

## Operation

- p = polarity_out; 0 at reset, inverts every edge afterwards.
- Accept phase: VC a = ~p. Requester i eligible iff req_v[i] and req_d[i][DATA_W-1]==a and occ_a < DEPTH.
- Round-robin pointer rr (reset 0). Search eligible requesters from rr upward with wrap; first found gets gnt[i]=1. At most one grant per cycle. On grant, rr <= (i+1) mod N_IN. No grant: rr unchanged.
- Granted packet pushed at buffer a tail at the edge; occ_a += 1. Requester holds req_v/req_d until granted. Ungranted requests are never lost or reordered.
- Send phase: VC s = p. If ro=1 and occ_s>0: pop head at the edge, so<=1, do<=head, occ_s -= 1. Otherwise so<=0, do<=0.
- Push and pop always target different VCs in the same cycle. No same-buffer read/write collision exists.
- FIFO order per VC. No ordering guarantee between VCs.
- A full VC buffer blocks only its own VC requests. The other VC proceeds.
- ro is sampled only in the send-phase cycle. No combinational path from ro to any output.

## Timing

- Reset low (async): polarity_out=0, so=0, do=0, gnt=0, occ0=occ1=0, rr=0, buffers emptied immediately.
- First edge after reset release: polarity_out goes 1.
- Packet with VC bit v is granted only in cycles with polarity_out = ~v.
- Minimum latency is 2 cycles. Grant in cycle C0, pop at the end of C1 (polarity_out=v, ro=1), so=1 in C2.
- While so=1, do[DATA_W-1] == ~... equals the VC popped; polarity_out == ~do[DATA_W-1].
- Peak throughput is one packet per VC every 2 cycles (link total 1/cycle).
- Reset asserted mid-operation: buffered packets are discarded, not sent. so drops to 0 at once. Requesters must re-present.
- occ outputs update at the same edge as push/pop.

## Test plan

- Reset: hold reset=0 for 2 cycles with req_v=4'hF. All outputs stay 0. After release, polarity_out reads 1,0,1,0 on successive cycles.
- Single packet, ro=1: req_d[0]=64'h200200000000FA50 (VC0), req_v=4'b0001. gnt[0]=1 only in the first cycle with polarity_out=1. Two cycles later, so=1, do=64'h200200000000FA50, polarity_out=1. occ0 goes 1 then 0.
- Round-robin: four VC0 packets 64'h2002000000006840 +i on all requesters, ro=1. Grants go 0,1,2,3 on consecutive VC0 accept cycles. do shows the packets in the same order, one every 2 cycles.
- Backpressure/full, DEPTH=2, ro=0: requesters 0..3 carry VC1 packets 64'hA002000000000001..4. Exactly 2 grants occur (req 0, 1), then occ1=2 and gnt=0. Set ro=1: packets ...01, ...02 appear, then req 2 and req 3 are granted and sent in order.
- VC independence: VC1 buffer full with ro=0, and a VC0 packet 64'h400200000000C7D4 is presented. The VC0 packet is granted and sent while occ1 stays 2. A mismatched-VC request is never granted in the wrong phase.
- Mid-operation reset: with occ0=1 and occ1=2, pulse reset low for 1 cycle. occ0=occ1=0, so=0, do=0 immediately. After release, no stale packet ever appears on do.
